// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter
// ----------------
// Two-requester APB master front end for the GPIO controller's APB slave.
// Picks one pending request round-robin, runs the APB SETUP/ACCESS sequence
// and returns the read data or error to the requester that was granted.
// With RD_LAG=1 the slave's PRDATA/PSLVERR are registered, so they are sampled
// one cycle after the PREADY=1 access edge, in CAPTURE. A transfer that holds
// PREADY low for TIMEOUT consecutive ACCESS cycles is aborted with err=1.
//
// Requester handshake (applies to r0_* and r1_*): rN_valid is held with
// stable write/addr/wdata until rN_ready is seen high on a rising edge. The
// request is accepted on that edge. The requester may drop rN_valid before
// that edge instead, and then no transfer happens. rN_ready is combinational.
// It is only ever high in IDLE, only for the granted requester, and never
// during PRESET. The result comes back later as a one-cycle rN_done pulse
// with rN_rdata/rN_err.
//
// Parameters:
//   RD_LAG    0: sample PRDATA/PSLVERR on the access edge; 1: one cycle later
//   TIMEOUT   PREADY=0 ACCESS cycles tolerated before abort (>= 1)
// Ports:
//   PCLK, PRESET               clock, synchronous active-high reset
//   rN_valid/write/addr/wdata  request from requester N (N = 0, 1)
//   rN_ready                   request accepted this cycle
//   rN_done/rdata/err          completion pulse, read data, error flag
//   PSEL, PENABLE, PWRITE      APB control
//   PADDR, PWDATA              APB address {24'h0, addr} and write data
//   PRDATA, PREADY, PSLVERR    APB slave response
//   o_dbg_state                FSM state: IDLE=0 SETUP=1 ACCESS=2 CAPTURE=3 DONE=4
module gpio_apb_arbiter #(
  parameter int RD_LAG  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        r0_valid,
  input  logic        r0_write,
  input  logic [7:0]  r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic        r0_done,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_valid,
  input  logic        r1_write,
  input  logic [7:0]  r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ready,
  output logic        r1_done,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic [2:0]  o_dbg_state
);

  // The wait counter only has to reach TIMEOUT-1 before the abort fires.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_gnt_id;
  logic [CW-1:0] r_wait_cnt;
  logic          r_write;
  logic [7:0]    r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;
  logic          r_err0;
  logic          r_err1;

  logic          w_gnt_id;
  logic          w_accept;
  logic          w_sample;
  logic          w_abort;
  logic [31:0]   w_res_rdata;
  logic          w_res_err;

  always_comb begin
    w_next   = r_state;
    w_gnt_id = 1'b0;
    w_accept = 1'b0;
    w_sample = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Both pending: favour whoever was not served last.
        if (r0_valid && r1_valid) begin
          w_gnt_id = ~r_last_grant;
        end else begin
          w_gnt_id = r1_valid;
        end
        w_accept = (r0_valid || r1_valid) && !PRESET;
        if (w_accept) begin
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (RD_LAG != 0) begin
            w_next = S_CAPTURE;
          end else begin
            w_sample = 1'b1;
            w_next   = S_DONE;
          end
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle with PREADY low.
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_CAPTURE: begin
        w_sample = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // A write returns zero read data. An abort ignores the bus entirely.
  always_comb begin
    w_res_rdata = 32'h0;
    w_res_err   = 1'b0;
    if (w_abort) begin
      w_res_err = 1'b1;
    end else if (w_sample) begin
      w_res_rdata = r_write ? 32'h0 : PRDATA;
      w_res_err   = PSLVERR;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_wait_cnt   <= '0;
      r_write      <= 1'b0;
      r_addr       <= 8'h0;
      r_wdata      <= 32'h0;
      r_rdata0     <= 32'h0;
      r_rdata1     <= 32'h0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt_id <= w_gnt_id;
        r_write  <= w_gnt_id ? r1_write : r0_write;
        r_addr   <= w_gnt_id ? r1_addr  : r0_addr;
        r_wdata  <= w_gnt_id ? r1_wdata : r0_wdata;
      end
      if (r_state == S_SETUP) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_ACCESS && !PREADY) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end
      // Only the owner's result registers change; the other requester keeps its outputs.
      if (w_sample || w_abort) begin
        if (r_gnt_id) begin
          r_rdata1 <= w_res_rdata;
          r_err1   <= w_res_err;
        end else begin
          r_rdata0 <= w_res_rdata;
          r_err0   <= w_res_err;
        end
      end
      if (r_state == S_DONE) begin
        r_last_grant <= r_gnt_id;
      end
    end
  end

  assign r0_ready    = w_accept && !w_gnt_id;
  assign r1_ready    = w_accept &&  w_gnt_id;
  assign r0_done     = (r_state == S_DONE) && !r_gnt_id;
  assign r1_done     = (r_state == S_DONE) &&  r_gnt_id;
  assign r0_rdata    = r_rdata0;
  assign r1_rdata    = r_rdata1;
  assign r0_err      = r_err0;
  assign r1_err      = r_err1;
  assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE     = (r_state == S_ACCESS);
  assign PWRITE      = r_write;
  assign PADDR       = {24'h0, r_addr};
  assign PWDATA      = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Testbench for gpio_apb_arbiter (RD_LAG=1, TIMEOUT=16).
// The APB slave is registered. It returns data one cycle after the access edge
// and drives junk on PRDATA/PSLVERR in every other cycle. Addresses 0x40 and
// above answer with PSLVERR=1. Address 0xF0 never raises PREADY.
module tb_gpio_apb_arbiter;

  localparam int         RD_LAG  = 1;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] TO_ADDR = 8'hF0;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        r0_valid = 1'b0, r0_write = 1'b0;
  logic [7:0]  r0_addr = 8'h0;
  logic [31:0] r0_wdata = 32'h0;
  logic        r1_valid = 1'b0, r1_write = 1'b0;
  logic [7:0]  r1_addr = 8'h0;
  logic [31:0] r1_wdata = 32'h0;
  logic        r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [2:0]  o_dbg_state;

  gpio_apb_arbiter #(.RD_LAG(RD_LAG), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          expc_q0[$];
  int          expc_q1[$];
  int          wait_q[$];
  int          acc_order[$];
  int          rdy_cnt0 = 0, rdy_cnt1 = 0;
  int          done_cnt0 = 0, done_cnt1 = 0;
  logic [31:0] model_mem[256];
  logic [31:0] slave_mem[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour of one transfer at the requester boundary.
  function automatic logic [32:0] model_xfer(input logic w, input logic [7:0] a, input logic [31:0] d);
    if (a == TO_ADDR) return {1'b1, 32'h0};
    if (a >= 8'h40)   return {1'b1, w ? 32'h0 : model_mem[a]};
    if (w) begin
      model_mem[a] = d;
      return {1'b0, 32'h0};
    end
    return {1'b0, model_mem[a]};
  endfunction

  function automatic logic get_ready(input int n);
    return (n == 0) ? r0_ready : r1_ready;
  endfunction

  task automatic set_req(input int n, input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    if (n == 0) begin
      r0_valid = v; r0_write = w; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_write = w; r1_addr = a; r1_wdata = d;
    end
  endtask

  // ---------------- driver ----------------
  // Raises valid at a falling edge and waits for ready. On acceptance it
  // pushes the predicted result and completion cycle, then returns just after
  // the accepting edge. Valid stays high only when keep=1.
  task automatic do_req(input int n, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input int waits, input bit keep, output int acc_cyc);
    int          guard;
    logic [32:0] e;
    int          ec;
    guard   = 0;
    acc_cyc = -1;
    @(negedge PCLK);
    set_req(n, 1'b1, w, a, d);
    #1;
    while (!get_ready(n) && guard < 300) begin
      @(negedge PCLK);
      #1;
      guard++;
    end
    if (!get_ready(n)) begin
      fail_now($sformatf("r%0d_accept_timeout", n), 0, 1);
      set_req(n, 1'b0, w, a, d);
      return;
    end
    acc_cyc = cyc;
    e  = model_xfer(w, a, d);
    ec = (a == TO_ADDR) ? acc_cyc + 2 + TIMEOUT : acc_cyc + 4 + waits;
    wait_q.push_back((a == TO_ADDR) ? 1000 : waits);
    acc_order.push_back(n);
    if (n == 0) begin exp_q0.push_back(e); expc_q0.push_back(ec); end
    else        begin exp_q1.push_back(e); expc_q1.push_back(ec); end
    @(posedge PCLK);
    #1;
    if (!keep) set_req(n, 1'b0, w, a, d);
  endtask

  task automatic rand_driver(input int n, input int count);
    int          c;
    int          sel;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    for (int k = 0; k < count; k++) begin
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      a   = 8'(4 * $urandom_range(0, 7));
      if (sel == 14) a = 8'h44;
      if (sel == 15) a = TO_ADDR;
      d = $urandom;
      do_req(n, w, a, d, $urandom_range(0, 3), 1'b0, c);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
  endtask

  task automatic clear_expect();
    exp_q0.delete(); exp_q1.delete();
    expc_q0.delete(); expc_q1.delete();
    wait_q.delete();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && g < 500) begin
      @(negedge PCLK);
      g++;
    end
    if ((exp_q0.size() + exp_q1.size()) != 0) begin
      fail_now("drain_pending", exp_q0.size() + exp_q1.size(), 0);
      clear_expect();
    end
    repeat (2) @(negedge PCLK);
  endtask

  // ---------------- APB slave (registered read data) ----------------
  initial begin : slave
    int          wait_left;
    bit          cap_pending;
    logic [31:0] cap_data;
    logic        cap_err;
    logic [7:0]  a;
    wait_left   = 0;
    cap_pending = 1'b0;
    cap_data    = 32'h0;
    cap_err     = 1'b0;
    forever begin
      @(negedge PCLK);
      PRDATA  = 32'hDEAD_BEEF;
      PSLVERR = 1'b1;
      if (cap_pending) begin
        PRDATA      = cap_data;
        PSLVERR     = cap_err;
        cap_pending = 1'b0;
      end
      if (PRESET || !PSEL) begin
        PREADY = 1'b0;
      end else if (!PENABLE) begin
        if (wait_q.size() > 0) wait_left = wait_q.pop_front();
        else                   wait_left = 0;
        PREADY = 1'b0;
      end else if (wait_left == 0) begin
        a       = PADDR[7:0];
        PREADY  = 1'b1;
        cap_err = (a >= 8'h40);
        if (PWRITE) begin
          cap_data = 32'h5A5A_5A5A;
          if (!cap_err) slave_mem[a] = PWDATA;
        end else begin
          cap_data = slave_mem[a];
        end
        cap_pending = 1'b1;
      end else begin
        wait_left--;
        PREADY = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic check_done(input int n);
    logic [32:0] e;
    int          ec;
    logic [31:0] rd;
    logic        er;
    rd = (n == 0) ? r0_rdata : r1_rdata;
    er = (n == 0) ? r0_err : r1_err;
    if ((n == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
      fail_now($sformatf("r%0d_unexpected_done", n), 1, 0);
    end else begin
      if (n == 0) begin e = exp_q0.pop_front(); ec = expc_q0.pop_front(); end
      else        begin e = exp_q1.pop_front(); ec = expc_q1.pop_front(); end
      check($sformatf("r%0d_rdata", n), 64'(rd), 64'(e[31:0]));
      check($sformatf("r%0d_err", n), 64'(er), 64'(e[32]));
      check($sformatf("r%0d_done_cycle", n), 64'(cyc), 64'(ec));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge PCLK);
      #2;
      if (r0_ready) rdy_cnt0++;
      if (r1_ready) rdy_cnt1++;
      if (r0_ready || r1_ready) check("ready_onehot", 64'(r0_ready & r1_ready), 64'(0));
      if (r0_done) begin done_cnt0++; check_done(0); end
      if (r1_done) begin done_cnt1++; check_done(1); end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int c, c0, c1, base, cnt0, cnt1, dsave0, dsave1, pen;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 32'h1000_0000 | i;
      slave_mem[i] = 32'h1000_0000 | i;
    end

    // Reset values, and no acceptance while PRESET is high.
    repeat (3) @(negedge PCLK);
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_done", 64'({r0_done, r1_done}), 64'(0));
    check("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'(0));
    check("rst_err", 64'({r0_err, r1_err}), 64'(0));
    check("rst_state", 64'(o_dbg_state), 64'(0));
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    check("rst_no_ready", 64'({r0_ready, r1_ready}), 64'(0));
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    PRESET   = 1'b0;

    // Directed write, zero-wait slave.
    do_req(0, 1'b1, 8'h04, 32'h0000_00FF, 0, 1'b0, c);
    @(negedge PCLK);
    check("wr_setup_psel", 64'(PSEL), 64'(1));
    check("wr_setup_penable", 64'(PENABLE), 64'(0));
    check("wr_paddr", 64'(PADDR), 64'(32'h04));
    check("wr_pwdata", 64'(PWDATA), 64'(32'hFF));
    check("wr_pwrite", 64'(PWRITE), 64'(1));
    @(negedge PCLK);
    check("wr_access_psel", 64'(PSEL), 64'(1));
    check("wr_access_penable", 64'(PENABLE), 64'(1));
    wait_idle();

    // Directed read by r1, with r0 raising and withdrawing valid meanwhile.
    cnt0 = rdy_cnt0;
    do_req(1, 1'b0, 8'h04, 32'h0, 0, 1'b0, c);
    @(negedge PCLK);
    r0_valid = 1'b1;
    @(negedge PCLK);
    r0_valid = 1'b0;
    wait_idle();
    check("withdraw_no_ready", 64'(rdy_cnt0), 64'(cnt0));

    // Slave error, then a clean transfer, then a read of the error address.
    do_req(0, 1'b1, 8'h40, 32'h1234_5678, 1, 1'b0, c);
    wait_idle();
    do_req(0, 1'b1, 8'h04, 32'h0000_00AB, 2, 1'b0, c);
    wait_idle();
    do_req(1, 1'b0, 8'h40, 32'h0, 0, 1'b0, c);
    wait_idle();

    // PREADY timeout.
    do_req(0, 1'b0, TO_ADDR, 32'h0, 0, 1'b0, c);
    @(negedge PCLK);
    pen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (!PENABLE) break;
      pen++;
    end
    check("to_penable_cycles", 64'(pen), 64'(TIMEOUT));
    check("to_psel_after", 64'(PSEL), 64'(0));
    @(negedge PCLK);
    check("to_state_idle", 64'(o_dbg_state), 64'(0));
    wait_idle();

    // Round-robin from reset with both requesters always pending.
    @(negedge PCLK);
    PRESET = 1'b1;
    clear_expect();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    base = acc_order.size();
    cnt0 = rdy_cnt0;
    cnt1 = rdy_cnt1;
    fork
      begin
        for (int k = 0; k < 4; k++) do_req(0, 1'b1, 8'(8 + 4 * k), $urandom, 0, (k != 3), c0);
      end
      begin
        for (int k = 0; k < 4; k++) do_req(1, 1'b0, 8'(4 * k), 32'h0, 0, (k != 3), c1);
      end
    join
    wait_idle();
    check("rr_count", 64'(acc_order.size() - base), 64'(8));
    for (int k = 0; k < 8 && base + k < acc_order.size(); k++)
      check($sformatf("rr_order_%0d", k), 64'(acc_order[base + k]), 64'(k % 2));
    check("rr_ready_pulses_r0", 64'(rdy_cnt0 - cnt0), 64'(4));
    check("rr_ready_pulses_r1", 64'(rdy_cnt1 - cnt1), 64'(4));

    // Randomised traffic from both requesters.
    fork
      rand_driver(0, 14);
      rand_driver(1, 14);
    join
    wait_idle();

    // Reset while in ACCESS: the in-flight transfer must vanish.
    do_req(0, 1'b0, 8'h08, 32'h0, 3, 1'b0, c);
    @(negedge PCLK);
    @(negedge PCLK);
    check("mid_rst_in_access", 64'(PENABLE), 64'(1));
    PRESET = 1'b1;
    clear_expect();
    dsave0 = done_cnt0;
    dsave1 = done_cnt1;
    @(negedge PCLK);
    check("mid_rst_psel", 64'(PSEL), 64'(0));
    check("mid_rst_penable", 64'(PENABLE), 64'(0));
    check("mid_rst_state", 64'(o_dbg_state), 64'(0));
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (6) @(negedge PCLK);
    check("mid_rst_no_done", 64'(done_cnt0 + done_cnt1), 64'(dsave0 + dsave1));
    base = acc_order.size();
    fork
      do_req(0, 1'b0, 8'h0C, 32'h0, 0, 1'b0, c0);
      do_req(1, 1'b1, 8'h10, 32'hCAFE_0010, 0, 1'b0, c1);
    join
    wait_idle();
    if (acc_order.size() > base) check("post_rst_first_grant", 64'(acc_order[base]), 64'(0));
    else fail_now("post_rst_first_grant_missing", acc_order.size() - base, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_apb_arbiter.md
# gpio_apb_arbiter

- Two-port APB master front end for the GPIO controller's APB slave port.
- Arbitrates round-robin between two requesters, such as the CPU bridge and the interrupt-service sequencer.
- Runs the APB SETUP/ACCESS sequence for the granted transfer and returns read data or error to that requester.
- Handles the GPIO's registered PRDATA/PSLVERR (one-cycle lag) and aborts hung transfers with a PREADY timeout.

## Interface
- RD_LAG, 1: cycles after the PREADY=1 access edge before PRDATA/PSLVERR are sampled (0 or 1).
- TIMEOUT, 16: consecutive ACCESS cycles with PREADY=0 before abort (≥1).
- PCLK  in  1  the single clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- rN_valid  in  1  request pending, N∈{0,1}; held until rN_ready or withdrawn.
- rN_write  in  1  1=write, 0=read.
- rN_addr  in  8  register offset.
- rN_wdata  in  32  write data.
- rN_ready  out  1  combinational; request accepted this cycle.
- rN_done  out  1  one-cycle completion pulse.
- rN_rdata  out  32  read data, valid with rN_done; 0 for writes and aborts.
- rN_err  out  1  slave error or timeout, valid with rN_done.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  32  {24'h0, latched addr}.
- PWDATA  out  32  latched wdata.
- PRDATA  in  32  slave read data.
- PREADY, PSLVERR  in  1  slave ready / error.

## Operation
- States: IDLE, SETUP, ACCESS, CAPTURE, DONE.
- IDLE, grant:
  - Only one rN_valid: grant it.
  - Both valid: grant the requester not granted last.
  - last_grant resets to 1, so r0 wins the first tie.
- IDLE, accept:
  - rN_ready=1 combinationally for the granted requester only.
  - Latch write/addr/wdata and the grant ID; go to SETUP.
  - No valid: stay in IDLE.
- Withdrawal: a requester may drop valid before ready; no transfer results.
- SETUP: PSEL=1, PENABLE=0; go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: go to CAPTURE if RD_LAG=1, else sample PRDATA/PSLVERR this cycle and go to DONE.
  - PREADY=0: increment the wait counter.
  - Counter reaches TIMEOUT: abort to DONE with err=1, rdata=0; CAPTURE is skipped.
- CAPTURE: PSEL=PENABLE=0; sample PRDATA (reads only) and PSLVERR; go to DONE.
- DONE:
  - Pulse done for the latched requester with registered rdata/err.
  - Update last_grant; go to IDLE.
  - The other requester's outputs are unchanged.
- PADDR/PWRITE/PWDATA hold their last latched values outside transfers.
- One transfer in flight at a time; no pipelining.

## Timing
- Reset values:
  - All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rN_done, rN_rdata, rN_err.
  - State IDLE, wait counter 0, last_grant=1.
- Transfer timeline, accept in cycle c, zero-wait slave:
  - SETUP at c+1, ACCESS at c+2.
  - RD_LAG=1: CAPTURE at c+3, rN_done at c+4.
  - RD_LAG=0: rN_done at c+3.
- Throughput: next accept earliest at c+5 (RD_LAG=1) or c+4 (RD_LAG=0).
- Wait states: each PREADY=0 ACCESS cycle adds one cycle of latency.
- Abort: done asserted the cycle after the TIMEOUT-th waiting ACCESS cycle.
- PRESET in any state: next edge forces IDLE with PSEL=PENABLE=0; no done pulse for the in-flight transfer.
- A request valid during reset is not accepted until PRESET deasserts.

## Test plan
- Write, RD_LAG=1: r0 writes addr 0x04, data 0x0000_00FF; slave PREADY=1.
  - Required: PSEL at c+1, PENABLE at c+2, PADDR=0x04, PWDATA=0xFF, PWRITE=1.
  - Required: r0_done at c+4 with r0_err=0, r0_rdata=0.
- Read: r1 reads 0x04; registered slave model returns 0x0000_00FF one cycle after the access edge.
  - Required: r1_rdata=0x0000_00FF, r1_err=0, r1_done at c+4.
- Round-robin: r0 and r1 held valid continuously from reset with four requests each.
  - Required: grant order r0,r1,r0,r1,…; each rN_ready pulse exactly once per transfer.
- Slave error: write to 0x40; slave asserts registered PSLVERR=1.
  - Required: r0_done with r0_err=1; next transfer to 0x04 completes with err=0.
- Timeout: PREADY held 0, TIMEOUT=16.
  - Required: PENABLE high for exactly 16 cycles, then PSEL=0.
  - Required: r0_done with r0_err=1, r0_rdata=0; FSM in IDLE the next cycle.
- Reset mid-transfer: PRESET asserted while in ACCESS.
  - Required: next cycle PSEL=PENABLE=0, no rN_done.
  - Required: after release, a simultaneous r0/r1 request grants r0.
